// File: rtl/fxp_row_acc_pkg.sv
// Shared constants and state encoding for the dynamic-Q row accumulator.
package fxp_row_acc_pkg;

    localparam int unsigned FXP_WORD_SIZE = 16;
    localparam int unsigned FXP_Q_W       = 4;

    localparam logic [FXP_Q_W-1:0] FXP_QI_MAX  = 4'd15;
    localparam logic [FXP_Q_W-1:0] FXP_CNT_MAX = 4'd15;

    typedef enum logic [1:0] {
        StFirst,
        StAcc,
        StDone
    } state_e;

endpackage

// File: rtl/fxp_align.sv
// Aligns two dynamic-Q operands to the format with the smaller fractional width.
module fxp_align
    import fxp_row_acc_pkg::*;
#(
    parameter int unsigned WORD_SIZE = FXP_WORD_SIZE
) (
    input  logic [WORD_SIZE-1:0] a_data,
    input  logic [FXP_Q_W-1:0]   a_qi,
    input  logic [FXP_Q_W-1:0]   a_qf,
    input  logic [WORD_SIZE-1:0] b_data,
    input  logic [FXP_Q_W-1:0]   b_qi,
    input  logic [FXP_Q_W-1:0]   b_qf,
    output logic [WORD_SIZE-1:0] a_al,
    output logic [WORD_SIZE-1:0] b_al,
    output logic [FXP_Q_W-1:0]   com_qi,
    output logic [FXP_Q_W-1:0]   com_qf
);

    // On equal QF the a-side format wins, so a stream of identical formats never drifts.
    always_comb begin
        a_al   = a_data;
        b_al   = b_data;
        com_qi = a_qi;
        com_qf = a_qf;
        if (a_qf > b_qf) begin
            a_al   = $signed(a_data) >>> (a_qf - b_qf);
            com_qi = b_qi;
            com_qf = b_qf;
        end else begin
            b_al = $signed(b_data) >>> (b_qf - a_qf);
        end
    end

endmodule

// File: rtl/fxp_row_acc.sv
// Streaming row accumulator: aligns each dynamic-Q term to the running sum, adds,
// renormalises by one step, and presents one result word per row.
module fxp_row_acc
    import fxp_row_acc_pkg::*;
#(
    parameter int unsigned WORD_SIZE = FXP_WORD_SIZE,
    parameter int unsigned N_TERMS   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic [FXP_Q_W-1:0]   in_qi,
    input  logic [FXP_Q_W-1:0]   in_qf,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic [FXP_Q_W-1:0]   out_qi,
    output logic [FXP_Q_W-1:0]   out_qf,
    output logic                 out_sat,
    output logic                 out_err
);

    localparam logic [WORD_SIZE-1:0] SAT_POS = {1'b0, {(WORD_SIZE-1){1'b1}}};
    localparam logic [WORD_SIZE-1:0] SAT_NEG = {1'b1, {(WORD_SIZE-1){1'b0}}};

    state_e                state_q, state_d;
    logic [WORD_SIZE-1:0]  acc_q, acc_d;
    logic [FXP_Q_W-1:0]    qi_q, qi_d, qf_q, qf_d, cnt_q, cnt_d;
    logic                  sat_q, sat_d, err_q, err_d;

    logic [WORD_SIZE-1:0]        a_raw, b_raw;
    logic signed [WORD_SIZE-1:0] a_al, b_al, sum, half_sum;
    logic [FXP_Q_W-1:0]          com_qi, com_qf, cnt_inc;
    logic                        xfer, fmt_bad, ovf, unf;

    fxp_align #(
        .WORD_SIZE(WORD_SIZE)
    ) u_align (
        .a_data(acc_q),
        .a_qi  (qi_q),
        .a_qf  (qf_q),
        .b_data(in_data),
        .b_qi  (in_qi),
        .b_qf  (in_qf),
        .a_al  (a_raw),
        .b_al  (b_raw),
        .com_qi(com_qi),
        .com_qf(com_qf)
    );

    assign a_al     = a_raw;
    assign b_al     = b_raw;
    assign sum      = a_al + b_al;
    assign half_sum = (a_al >>> 1) + (b_al >>> 1);
    assign ovf      = (a_al[WORD_SIZE-1] == b_al[WORD_SIZE-1]) &&
                      (sum[WORD_SIZE-1] != a_al[WORD_SIZE-1]);
    // Two equal top bits mean the sum wastes an integer bit.
    assign unf      = (sum[WORD_SIZE-1] == sum[WORD_SIZE-2]) && (com_qi > 4'd1);
    assign cnt_inc  = (cnt_q == FXP_CNT_MAX) ? cnt_q : cnt_q + 4'd1;
    assign fmt_bad  = (in_qi == '0) || (in_qf == '0) ||
                      ((32'(in_qi) + 32'(in_qf)) != WORD_SIZE);

    // Gated by rst_n so the block never advertises readiness while held in reset.
    assign in_ready = rst_n && (state_q != StDone);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        qi_d    = qi_q;
        qf_d    = qf_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        err_d   = err_q;
        unique case (state_q)
            StFirst: begin
                if (xfer) begin
                    acc_d   = in_data;
                    qi_d    = in_qi;
                    qf_d    = in_qf;
                    cnt_d   = 4'd1;
                    err_d   = err_q || fmt_bad || (in_last && (N_TERMS != 1));
                    state_d = in_last ? StDone : StAcc;
                end
            end
            StAcc: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    err_d = err_q || fmt_bad || (in_last && (32'(cnt_inc) != N_TERMS));
                    qi_d  = com_qi;
                    qf_d  = com_qf;
                    if (ovf) begin
                        if (com_qi < FXP_QI_MAX) begin
                            acc_d = half_sum;
                            qi_d  = com_qi + 4'd1;
                            qf_d  = com_qf - 4'd1;
                        end else begin
                            acc_d = a_al[WORD_SIZE-1] ? SAT_NEG : SAT_POS;
                            sat_d = 1'b1;
                        end
                    end else if (unf) begin
                        acc_d = {sum[WORD_SIZE-2:0], 1'b0};
                        qi_d  = com_qi - 4'd1;
                        qf_d  = com_qf + 4'd1;
                    end else begin
                        acc_d = sum;
                    end
                    if (in_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StFirst;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StFirst;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFirst;
            acc_q   <= '0;
            qi_q    <= '0;
            qf_q    <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            qi_q    <= qi_d;
            qf_q    <= qf_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign out_data  = acc_q;
    assign out_qi    = qi_q;
    assign out_qf    = qf_q;
    assign out_sat   = sat_q;
    assign out_err   = err_q;

endmodule
